// File: rtl/regs_file_mp_pkg.sv
// ----------------------------------------------------------------------------
// regs_file_mp_pkg
//   Shared constants for the multi-port integer register file and the
//   pipeline trace helpers.
//
//   Contents:
//     DataWidth / AddrWidth / RegNumWidth : default widths (RV32)
//     REG_ZERO                            : hard-wired zero register index
//     `REGS_SLICE(vec, idx, w)            : selects field idx of width w from a
//                                           packed per-port vector
//
//   Optional build macro used by regs_file_mp: REGS_FILE_TRACE_EN
// ----------------------------------------------------------------------------
`ifndef REGS_FILE_MP_PKG_SV
`define REGS_FILE_MP_PKG_SV

// Port k of a packed multi-port bus lives at bits [k*w +: w].
`define REGS_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regs_file_mp_pkg;

   localparam int DataWidth   = 32;
   localparam int AddrWidth   = 32;
   localparam int RegNumWidth = 5;

   // Index of the architectural zero register (reads 0, never written).
   localparam int REG_ZERO    = 0;

endpackage

`endif

// File: rtl/regs_pc_delay.sv
// ----------------------------------------------------------------------------
// regs_pc_delay
//   Fixed-latency PC delay line. The PC of the instruction entering the
//   pipeline is shifted through PC_DEPTH stages so that write-back logic
//   sees the PC of the instruction it is retiring. No enable: the line
//   advances every cycle, so pc_out is exactly pc_in from PC_DEPTH cycles ago.
//
//   Parameters:
//     ADDR_W   : PC width
//     PC_DEPTH : number of stages (>= 1)
//
//   Ports:
//     clk    in  1       rising-edge clock
//     reset  in  1       asynchronous active-high reset, clears all stages
//     pc_in  in  ADDR_W  PC entering the pipeline
//     pc_out out ADDR_W  oldest stage
// ----------------------------------------------------------------------------
module regs_pc_delay
   import regs_file_mp_pkg::*;
#(
   parameter int ADDR_W   = AddrWidth,
   parameter int PC_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] pc_out
);

   logic [ADDR_W-1:0] stage_q [PC_DEPTH];

   // Stage 0 captures the incoming PC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q[0] <= '0;
      end else begin
         stage_q[0] <= pc_in;
      end
   end

   // Remaining stages each take the previous one.
   genvar gi;
   generate
      for (gi = 1; gi < PC_DEPTH; gi++) begin : g_stage
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               stage_q[gi] <= '0;
            end else begin
               stage_q[gi] <= stage_q[gi-1];
            end
         end
      end
   endgenerate

   assign pc_out = stage_q[PC_DEPTH-1];

endmodule

// File: rtl/regs_file_mp.sv
// ----------------------------------------------------------------------------
// regs_file_mp
//   Multi-port integer register file for the pipelined RV32 core.
//   - RD_PORTS combinational read ports with same-cycle write bypass
//   - WR_PORTS write ports; on an index collision the highest port wins
//   - per-register pending-write scoreboard (busy bits) for hazard detection
//   - PC delay line tagging each write-back with its instruction PC
//   - watch port returning the stored value (no bypass) for debug display
//   Register 0 always reads 0, ignores writes/issues and is never busy.
//
//   Optional build macro: REGS_FILE_TRACE_EN
//     defined   : each committed write prints "pc = <pc_wb>: x<n> = <data>"
//                 in simulation, one line per winning port, in port order
//     undefined : no print code; function identical either way
//
//   Ports:
//     clk        in  1                    rising-edge clock
//     reset      in  1                    asynchronous active-high reset
//     wr_en      in  WR_PORTS             per-port write enable
//     wr_num     in  WR_PORTS*REG_NUM_W   per-port destination index
//     wr_data    in  WR_PORTS*DATA_W      per-port write data
//     rd_num     in  RD_PORTS*REG_NUM_W   per-port source index
//     rd_data    out RD_PORTS*DATA_W      per-port read data (bypassed)
//     rd_busy    out RD_PORTS             source still pending after bypass
//     issue_en   in  1                    mark issue_num pending
//     issue_num  in  REG_NUM_W            destination of issuing instruction
//     pc_in      in  ADDR_W               PC entering the pipeline
//     pc_wb      out ADDR_W               pc_in delayed PC_DEPTH cycles
//     watch_num  in  REG_NUM_W            debug index
//     watch_data out DATA_W               stored value of watch_num
// ----------------------------------------------------------------------------
module regs_file_mp
   import regs_file_mp_pkg::*;
#(
   parameter int DATA_W    = DataWidth,
   parameter int ADDR_W    = AddrWidth,
   parameter int REG_NUM_W = RegNumWidth,
   parameter int RD_PORTS  = 2,
   parameter int WR_PORTS  = 2,
   parameter int PC_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WR_PORTS-1:0]           wr_en,
   input  logic [WR_PORTS*REG_NUM_W-1:0] wr_num,
   input  logic [WR_PORTS*DATA_W-1:0]    wr_data,
   input  logic [RD_PORTS*REG_NUM_W-1:0] rd_num,
   output logic [RD_PORTS*DATA_W-1:0]    rd_data,
   output logic [RD_PORTS-1:0]           rd_busy,
   input  logic                          issue_en,
   input  logic [REG_NUM_W-1:0]          issue_num,
   input  logic [ADDR_W-1:0]             pc_in,
   output logic [ADDR_W-1:0]             pc_wb,
   input  logic [REG_NUM_W-1:0]          watch_num,
   output logic [DATA_W-1:0]             watch_data
);

   localparam int NREGS = 2**REG_NUM_W;
   localparam logic [REG_NUM_W-1:0] ZERO_IDX = REG_NUM_W'(REG_ZERO);

   // ------------------------------------------------------------------
   // Unpacked view of the write ports
   // ------------------------------------------------------------------
   logic [REG_NUM_W-1:0] wr_idx [WR_PORTS];
   logic [DATA_W-1:0]    wr_val [WR_PORTS];
   logic [WR_PORTS-1:0]  wr_act;     // enabled and not targeting x0

   genvar gi;
   generate
      for (gi = 0; gi < WR_PORTS; gi++) begin : g_wr
         assign wr_idx[gi] = `REGS_SLICE(wr_num, gi, REG_NUM_W);
         assign wr_val[gi] = `REGS_SLICE(wr_data, gi, DATA_W);
         assign wr_act[gi] = wr_en[gi] && (wr_idx[gi] != ZERO_IDX);
      end
   endgenerate

   // ------------------------------------------------------------------
   // Storage. Ports are applied in ascending order so the last
   // (highest-index) nonblocking assignment wins a collision.
   // x0 is never written, so it keeps its reset value of zero.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int k = 0; k < WR_PORTS; k++) begin
            if (wr_act[k]) begin
               regs_q[wr_idx[k]] <= wr_val[k];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard: write-backs clear first, then a new issue sets, so an
   // issue landing on the same index as a completing write stays busy.
   // ------------------------------------------------------------------
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < WR_PORTS; k++) begin
         if (wr_act[k]) begin
            busy_d[wr_idx[k]] = 1'b0;
         end
      end
      if (issue_en && (issue_num != ZERO_IDX)) begin
         busy_d[issue_num] = 1'b1;
      end
      busy_d[ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // ------------------------------------------------------------------
   // Read ports with same-cycle bypass. Scanning ports upward and keeping
   // the last match reproduces the write-collision priority.
   // ------------------------------------------------------------------
   generate
      for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
         logic [REG_NUM_W-1:0] src_idx;
         logic [DATA_W-1:0]    src_val;
         logic                 src_hit;

         assign src_idx = `REGS_SLICE(rd_num, gi, REG_NUM_W);

         always_comb begin
            src_hit = 1'b0;
            src_val = regs_q[src_idx];
            for (int k = 0; k < WR_PORTS; k++) begin
               if (wr_act[k] && (wr_idx[k] == src_idx)) begin
                  src_hit = 1'b1;
                  src_val = wr_val[k];
               end
            end
         end

         // wr_act already excludes x0 and busy_q[0] is held at zero, but the
         // explicit guard keeps x0 reads independent of storage contents.
         assign `REGS_SLICE(rd_data, gi, DATA_W) =
            (src_idx == ZERO_IDX) ? '0 : src_val;
         assign rd_busy[gi] =
            (src_idx != ZERO_IDX) && busy_q[src_idx] && !src_hit;
      end
   endgenerate

   // Debug view: stored value only, no bypass.
   assign watch_data = regs_q[watch_num];

   // ------------------------------------------------------------------
   // PC delay line for write-back tagging
   // ------------------------------------------------------------------
   regs_pc_delay #(
      .ADDR_W   (ADDR_W),
      .PC_DEPTH (PC_DEPTH)
   ) u_pc_delay (
      .clk    (clk),
      .reset  (reset),
      .pc_in  (pc_in),
      .pc_out (pc_wb)
   );

`ifdef REGS_FILE_TRACE_EN
   // Print only ports whose write actually lands (no higher port to the
   // same index), in ascending port order.
   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < WR_PORTS; k++) begin
            if (wr_act[k]) begin
               logic shadowed;
               shadowed = 1'b0;
               for (int j = k + 1; j < WR_PORTS; j++) begin
                  if (wr_act[j] && (wr_idx[j] == wr_idx[k])) begin
                     shadowed = 1'b1;
                  end
               end
               if (!shadowed) begin
                  $display("pc = %h: x%0d = %h", pc_wb, wr_idx[k], wr_val[k]);
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_regs_file_mp.sv
module tb_regs_file_mp;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int RNW = 5;
   localparam int RDP = 2;
   localparam int WRP = 2;
   localparam int PCD = 4;
   localparam int NR  = 32;

   logic                 clk;
   logic                 reset;
   logic [WRP-1:0]       wr_en;
   logic [WRP*RNW-1:0]   wr_num;
   logic [WRP*DW-1:0]    wr_data;
   logic [RDP*RNW-1:0]   rd_num;
   logic [RDP*DW-1:0]    rd_data;
   logic [RDP-1:0]       rd_busy;
   logic                 issue_en;
   logic [RNW-1:0]       issue_num;
   logic [AW-1:0]        pc_in;
   logic [AW-1:0]        pc_wb;
   logic [RNW-1:0]       watch_num;
   logic [DW-1:0]        watch_data;

   int tests_run    = 0;
   int tests_failed = 0;

   regs_file_mp #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .REG_NUM_W (RNW),
      .RD_PORTS  (RDP),
      .WR_PORTS  (WRP),
      .PC_DEPTH  (PCD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_num     (wr_num),
      .wr_data    (wr_data),
      .rd_num     (rd_num),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .issue_en   (issue_en),
      .issue_num  (issue_num),
      .pc_in      (pc_in),
      .pc_wb      (pc_wb),
      .watch_num  (watch_num),
      .watch_data (watch_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: architectural register array, pending set and a
   // FIFO of PCs. Updated on each rising edge from the current inputs.
   // ------------------------------------------------------------------
   logic [DW-1:0] ref_regs [NR];
   logic [NR-1:0] ref_busy;
   logic [AW-1:0] ref_pc [$];

   always @(posedge clk or posedge reset) begin
      logic [NR-1:0] nb;
      logic [RNW-1:0] n;
      if (reset) begin
         for (int i = 0; i < NR; i++) ref_regs[i] = '0;
         ref_busy = '0;
         ref_pc.delete();
         for (int i = 0; i < PCD; i++) ref_pc.push_back('0);
      end else begin
         nb = ref_busy;
         for (int k = 0; k < WRP; k++) begin
            n = wr_num[k*RNW +: RNW];
            if (wr_en[k] && n != 0) begin
               ref_regs[n] = wr_data[k*DW +: DW];
               nb[n] = 1'b0;
            end
         end
         if (issue_en && issue_num != 0) nb[issue_num] = 1'b1;
         ref_busy = nb;
         ref_pc.push_back(pc_in);
         void'(ref_pc.pop_front());
      end
   end

   // Value a read of n should return this cycle (highest matching write wins).
   function automatic logic [DW-1:0] exp_rd(input logic [RNW-1:0] n);
      logic [DW-1:0] v;
      if (n == 0) return '0;
      v = ref_regs[n];
      for (int k = 0; k < WRP; k++)
         if (wr_en[k] && wr_num[k*RNW +: RNW] == n) v = wr_data[k*DW +: DW];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [RNW-1:0] n);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < WRP; k++)
         if (wr_en[k] && wr_num[k*RNW +: RNW] == n) hit = 1'b1;
      return (n != 0) && ref_busy[n] && !hit;
   endfunction

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic idle();
      wr_en     = '0;
      wr_num    = '0;
      wr_data   = '0;
      issue_en  = 1'b0;
      issue_num = '0;
      rd_num    = '0;
   endtask

   task automatic set_wr(input int k, input logic [RNW-1:0] n, input logic [DW-1:0] d);
      wr_en[k]              = 1'b1;
      wr_num[k*RNW +: RNW]  = n;
      wr_data[k*DW +: DW]   = d;
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      idle();
      pc_in     = 32'h1000;
      watch_num = 5'd9;
      rd_num    = {5'd17, 5'd4};
      #1;
      tests_run++;
      if (rd_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_rd_data: got %h expected 0", rd_data);
      end
      tests_run++;
      if (rd_busy !== '0 || pc_wb !== '0 || watch_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: busy %b pc_wb %h watch %h expected all 0",
                  rd_busy, pc_wb, watch_data);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_x0();
      @(negedge clk);
      idle();
      set_wr(0, 5'd0, 32'h1234);
      set_wr(1, 5'd0, 32'h5678);
      issue_en = 1'b1;
      issue_num = 5'd0;
      #1;
      tests_run++;
      if (rd_data[DW-1:0] !== '0 || rd_busy[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL x0_bypass: data %h busy %b expected 0/0", rd_data[DW-1:0], rd_busy[0]);
      end
      @(negedge clk);
      idle();
      watch_num = 5'd0;
      #1;
      tests_run++;
      if (rd_data !== '0 || rd_busy !== '0 || watch_data !== '0) begin
         tests_failed++;
         $display("FAIL x0_stored: data %h busy %b watch %h expected 0", rd_data, rd_busy, watch_data);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      idle();
      set_wr(0, 5'd3, 32'hA5A5A5A5);
      rd_num[RNW-1:0] = 5'd3;
      watch_num = 5'd3;
      #1;
      tests_run++;
      if (rd_data[DW-1:0] !== 32'hA5A5A5A5) begin
         tests_failed++;
         $display("FAIL bypass_same_cycle: got %h expected a5a5a5a5", rd_data[DW-1:0]);
      end
      tests_run++;
      if (watch_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL watch_no_bypass: got %h expected 0", watch_data);
      end
      @(negedge clk);
      idle();
      rd_num[RNW-1:0] = 5'd3;
      #1;
      tests_run++;
      if (rd_data[DW-1:0] !== 32'hA5A5A5A5 || watch_data !== 32'hA5A5A5A5) begin
         tests_failed++;
         $display("FAIL bypass_stored: rd %h watch %h expected a5a5a5a5", rd_data[DW-1:0], watch_data);
      end
   endtask

   task automatic test_collision();
      @(negedge clk);
      idle();
      set_wr(0, 5'd7, 32'h11);
      set_wr(1, 5'd7, 32'h22);
      rd_num = {5'd7, 5'd7};
      #1;
      tests_run++;
      if (rd_data !== {32'h22, 32'h22}) begin
         tests_failed++;
         $display("FAIL collision_bypass: got %h expected both 22", rd_data);
      end
      @(negedge clk);
      idle();
      watch_num = 5'd7;
      rd_num[RNW-1:0] = 5'd7;
      #1;
      tests_run++;
      if (watch_data !== 32'h22 || rd_data[DW-1:0] !== 32'h22) begin
         tests_failed++;
         $display("FAIL collision_stored: watch %h rd %h expected 22", watch_data, rd_data[DW-1:0]);
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      idle();
      issue_en  = 1'b1;
      issue_num = 5'd9;
      rd_num[RNW-1:0] = 5'd9;
      #1;
      tests_run++;
      if (rd_busy[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_issue_cycle: got %b expected 0", rd_busy[0]);
      end
      @(negedge clk);
      idle();
      rd_num = {5'd9, 5'd9};
      #1;
      tests_run++;
      if (rd_busy !== 2'b11) begin
         tests_failed++;
         $display("FAIL sb_busy_after_issue: got %b expected 11", rd_busy);
      end
      @(negedge clk);
      idle();
      set_wr(0, 5'd9, 32'hCAFE0009);
      issue_en  = 1'b1;
      issue_num = 5'd9;
      rd_num[RNW-1:0] = 5'd9;
      #1;
      tests_run++;
      if (rd_busy[0] !== 1'b0 || rd_data[DW-1:0] !== 32'hCAFE0009) begin
         tests_failed++;
         $display("FAIL sb_wb_bypass: busy %b data %h expected 0/cafe0009", rd_busy[0], rd_data[DW-1:0]);
      end
      @(negedge clk);
      idle();
      rd_num[RNW-1:0] = 5'd9;
      #1;
      tests_run++;
      if (rd_busy[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_reissue_wins: got %b expected 1", rd_busy[0]);
      end
      @(negedge clk);
      idle();
      set_wr(1, 5'd9, 32'h99);
      @(negedge clk);
      idle();
      rd_num[RNW-1:0] = 5'd9;
      #1;
      tests_run++;
      if (rd_busy[0] !== 1'b0 || rd_data[DW-1:0] !== 32'h99) begin
         tests_failed++;
         $display("FAIL sb_cleared: busy %b data %h expected 0/99", rd_busy[0], rd_data[DW-1:0]);
      end
   endtask

   task automatic test_pc_delay();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         idle();
         // This negedge follows rising edge number i since pc 0 was applied.
         if (i >= PCD) begin
            tests_run++;
            if (pc_wb !== 32'(4 * (i - PCD))) begin
               tests_failed++;
               $display("FAIL pc_delay[%0d]: got %h expected %h", i, pc_wb, 32'(4 * (i - PCD)));
            end
         end
         pc_in = 32'(4 * i);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      idle();
      set_wr(0, 5'd5, 32'hDEADBEEF);
      issue_en  = 1'b1;
      issue_num = 5'd6;
      pc_in     = 32'h4444;
      @(negedge clk);
      idle();
      rd_num    = {5'd6, 5'd5};
      watch_num = 5'd5;
      #1;
      tests_run++;
      if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_busy[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_pre: x5 %h busy6 %b expected deadbeef/1", rd_data[DW-1:0], rd_busy[1]);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (rd_data !== '0 || rd_busy !== '0 || pc_wb !== '0 || watch_data !== '0) begin
         tests_failed++;
         $display("FAIL midrst_async: rd %h busy %b pc_wb %h watch %h expected 0",
                  rd_data, rd_busy, pc_wb, watch_data);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [RNW-1:0] n;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         idle();
         // Narrow index range to provoke collisions, bypass hits and hazards.
         for (int k = 0; k < WRP; k++) begin
            if ($urandom_range(0, 2) != 0) begin
               n = RNW'($urandom_range(0, 7));
               set_wr(k, n, $urandom);
            end
         end
         issue_en  = ($urandom_range(0, 1) == 1);
         issue_num = RNW'($urandom_range(0, 7));
         for (int p = 0; p < RDP; p++) rd_num[p*RNW +: RNW] = RNW'($urandom_range(0, 7));
         watch_num = RNW'($urandom_range(0, NR - 1));
         pc_in     = $urandom;
         #1;
         for (int p = 0; p < RDP; p++) begin
            n = rd_num[p*RNW +: RNW];
            tests_run++;
            if (rd_data[p*DW +: DW] !== exp_rd(n)) begin
               tests_failed++;
               $display("FAIL rand_rd cyc %0d port %0d x%0d: got %h expected %h",
                        c, p, n, rd_data[p*DW +: DW], exp_rd(n));
            end
            tests_run++;
            if (rd_busy[p] !== exp_busy(n)) begin
               tests_failed++;
               $display("FAIL rand_busy cyc %0d port %0d x%0d: got %b expected %b",
                        c, p, n, rd_busy[p], exp_busy(n));
            end
         end
         tests_run++;
         if (watch_data !== ref_regs[watch_num]) begin
            tests_failed++;
            $display("FAIL rand_watch cyc %0d x%0d: got %h expected %h",
                     c, watch_num, watch_data, ref_regs[watch_num]);
         end
         tests_run++;
         if (pc_wb !== ref_pc[0]) begin
            tests_failed++;
            $display("FAIL rand_pc_wb cyc %0d: got %h expected %h", c, pc_wb, ref_pc[0]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      pc_in     = '0;
      watch_num = '0;
      test_reset();
      test_x0();
      test_bypass();
      test_collision();
      test_scoreboard();
      test_pc_delay();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
